// File: rtl/seq_sub64.sv
// Multi-cycle subtractor: diff = a - b - bIn computed as a + ~b + ~bIn, CHUNK bits per clock, LSB first.
// Define SEQ_SUB_FLAGS_EN to add registered zero/neg/ovf result flags.
module seq_sub64 #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bOut
`ifdef SEQ_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_n;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] diff_nx;

  // Only one CHUNK-wide adder; the inter-chunk carry lives in a register.
  always_comb begin
    a_chunk = a_r[idx*CHUNK +: CHUNK];
    b_chunk = b_n[idx*CHUNK +: CHUNK];
    sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    diff_nx = diff;
    diff_nx[idx*CHUNK +: CHUNK] = sum[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bOut      <= 1'b0;
      a_r       <= '0;
      b_n       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
`ifdef SEQ_SUB_FLAGS_EN
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_n      <= ~b;
            carry    <= ~bIn;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          diff  <= diff_nx;
          carry <= sum[CHUNK];
          if (idx == LAST) begin
            // A final carry of 0 means the subtraction borrowed.
            bOut      <= ~sum[CHUNK];
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SEQ_SUB_FLAGS_EN
            zero      <= (diff_nx == '0);
            neg       <= diff_nx[WIDTH-1];
            ovf       <= (a_r[WIDTH-1] == b_n[WIDTH-1]) &&
                         (diff_nx[WIDTH-1] != a_r[WIDTH-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sub64.sv
// Scoreboard bench for seq_sub64: expected results are queued at operand acceptance
// and compared when out_valid appears.
module tb_seq_sub64;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bIn;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bOut;
`ifdef SEQ_SUB_FLAGS_EN
  logic        zero;
  logic        neg;
  logic        ovf;
`endif

  seq_sub64 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bIn       (bIn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bOut      (bOut)
`ifdef SEQ_SUB_FLAGS_EN
    ,
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic        bo;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] op_a, input logic [63:0] op_b,
                                 input logic op_bin);
    exp_t        e;
    logic [64:0] full;
    full = {1'b0, op_a} - {1'b0, op_b} - {64'd0, op_bin};
    e.d  = full[63:0];
    e.bo = full[64];
    e.z  = (full[63:0] == 64'd0);
    e.n  = full[63];
    e.v  = (op_a[63] != op_b[63]) && (full[63] != op_a[63]);
    return e;
  endfunction

  // Present operands, wait for acceptance (bounded) and queue the expectation.
  task automatic drive_accept(input logic [63:0] op_a, input logic [63:0] op_b,
                              input logic op_bin, output bit ok);
    int w;
    @(negedge clk);
    a = op_a; b = op_b; bIn = op_bin; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    ok = in_ready;
    if (!ok) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(op_a, op_b, op_bin));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    bIn = ~op_bin;
  endtask

  task automatic run_op(input logic [63:0] op_a, input logic [63:0] op_b, input logic op_bin,
                        input int hold, input bit pulse, input bit early, input bit chk_lat);
    exp_t e;
    bit   ok;
    bit   got;
    int   lat;
    out_ready = early;
    drive_accept(op_a, op_b, op_bin, ok);
    if (!ok) return;
    check("in_ready_run", 64'(in_ready), 64'd0);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (pulse && i == 2) begin
        in_valid = 1'b1;
        a = 64'hDEAD_BEEF_0000_0001;
        b = 64'h0123_4567_89AB_CDEF;
      end
      if (i == 3) in_valid = 1'b0;
      @(posedge clk);
      #1;
      if (pulse && i == 2) check("in_ready_pulse", 64'(in_ready), 64'd0);
      if (out_valid) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    in_valid = 1'b0;
    if (!got) begin
      check("done_timeout", 64'(out_valid), 64'd1);
      out_ready = 1'b0;
      return;
    end
    if (chk_lat) check("latency", 64'(lat), 64'd4);
    if (sb.size() == 0) begin
      check("sb_underflow", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    check("diff", diff, e.d);
    check("bOut", 64'(bOut), 64'(e.bo));
`ifdef SEQ_SUB_FLAGS_EN
    check("zero", 64'(zero), 64'(e.z));
    check("neg",  64'(neg),  64'(e.n));
    check("ovf",  64'(ovf),  64'(e.v));
`endif
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        if (pulse && i == 3) begin
          in_valid = 1'b1;
          a = 64'h5555_5555_5555_5555;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_diff", diff, e.d);
        check("hold_bOut", 64'(bOut), 64'(e.bo));
        check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("drop_valid", 64'(out_valid), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    bit   ok;
    bit   seen;
    logic [63:0] ra;
    logic [63:0] rb;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bIn = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_diff", diff, 64'd0);
    check("rst_bOut", 64'(bOut), 64'd0);
    rst = 1'b0;

    run_op(64'd5, 64'd3, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    run_op(64'd0, 64'd1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    run_op(64'h1_0000_0000, 64'd0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    run_op(64'd42, 64'd42, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    run_op(64'd42, 64'd42, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    run_op(64'h0000_FFFF_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 10, 1'b1, 1'b0, 1'b1);

    // Abort mid-RUN: assert rst while idx=2.
    drive_accept(64'd100, 64'd7, 1'b0, ok);
    if (ok) begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_diff", diff, 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      void'(sb.pop_front());
      seen = 1'b0;
      repeat (8) begin
        @(posedge clk);
        #1;
        if (out_valid) seen = 1'b1;
      end
      check("abort_no_result", 64'(seen), 64'd0);
    end

`ifdef SEQ_SUB_FLAGS_EN
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = (i == 2) ? ra : {$urandom, $urandom};
      run_op(ra, rb, 1'($urandom_range(0, 1)), i % 3, 1'b0, (i % 2) == 1, 1'b1);
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
